subnode_link_ctrl: RTL and testbench
====================================

// Module: subnode_link_ctrl
// PURPOSE
//  Master-side sequencer for the serial encryption/decryption subnode link. Captures one message and one key
//  in parallel, frames them under cs, and shifts them out on sdi, MSB first: message first, then key.
//  It then waits a fixed processing gap and shifts the processed block back in from sdo, MSB first.
//  It presents the result in parallel with a done pulse. One instance serves one subnode.
// PARAMETERS
//  nk          8    key length in 32-bit words (key width = 32*nk)
//  nb          4    block length in 32-bit words (msg width = 8*4*nb)
//  nr          14   round count; informational, used only to size WAIT_CYC default
//  WAIT_CYC    nr+2 in_clk cycles cs stays low between last key bit and first result sample (>=1)
// PORTS
//  in_clk      in   1          link clock; all state on rising edge (subnode samples/drives on falling edge)
//  rst         in   1          asynchronous, active-low reset
//  start       in   1          request; accepted only in IDLE
//  msg_in      in   8*4*nb     message block, sampled on accepting edge
//  key_in      in   32*nk      key, sampled on accepting edge
//  sdo         in   1          serial return data from subnode
//  cs          out  1          chip select to subnode, active low
//  sdi         out  1          serial data to subnode
//  busy        out  1          high from accept until return to IDLE
//  done        out  1          one-cycle pulse, result valid
//  result      out  8*4*nb     processed block, held until next accept
// BEHAVIOUR
//  Reset (async, rst=0): state=IDLE, cs=1, sdi=0, busy=0, done=0, result=0, counters=0. Mid-transfer reset
//   aborts immediately and never yields done; cs high also resets the subnode's counters.
//  States: IDLE -> SEND_MSG -> SEND_KEY -> GAP -> RECV -> FIN -> IDLE.
//  IDLE: cs=1, sdi=0. On edge with start=1: latch {msg_in,key_in} into tx shift reg; cs<=0;
//   sdi<=msg_in[MSB]; busy<=1; bit_cnt<=0; go SEND_MSG. start=0: stay.
//  SEND_MSG: 8*4*nb cycles. Each edge: shift tx left, sdi<=next bit. After last msg bit go SEND_KEY.
//   Key MSB follows msg LSB with no gap.
//  SEND_KEY: 32*nk cycles, same shifting. After last key bit: sdi<=0, go GAP.
//  GAP: WAIT_CYC cycles, cs=0, sdi=0; cycle counter then go RECV.
//  RECV: 8*4*nb cycles. Each edge: rx <= {rx[W-2:0], sdo}. First sampled bit = result MSB.
//   After last sample go FIN.
//  FIN: result<=rx; done=1 (this cycle only); cs<=1; busy stays 1. Next edge goes IDLE with busy<=0.
//   Guarantees >=2 cycles of cs high between transactions.
//  cs low exactly W+32*nk+WAIT_CYC+W cycles per transaction, W=8*4*nb (default 128+256+16+128=528).
//  Latency start-accept to done: 529 cycles at defaults.
//  start while busy: ignored, not queued. start asserted on the FIN->IDLE edge: ignored.
//   Start must be seen in IDLE.
//  Counters: one bit counter, width clog2(max(W,32*nk,WAIT_CYC)+1), cleared on every state change.
//   No wrap-around is possible.
//  sdo X/Z during RECV is captured as-is. No checking, no timeout.
//  Parameters that change widths (nb,nk) resize buses only; state sequence unchanged.
// TESTING
//  1 Reset: rst=0 mid-SEND_KEY (cycle 200) -> cs=1, busy=0, done=0, result=0 asynchronously.
//    After release, idle until start.
//  2 Frame: start with msg=128'h00112233445566778899aabbccddeeff, key=256'h000102..1f -> sdi serial stream
//    equals msg bits 127..0 then key bits 255..0; cs low 528 cycles; done at cycle 529.
//  3 Loopback: bench model returns 128'hdeadbeef_... MSB first on sdo during RECV -> result equals
//    that value at done; held through 10 idle cycles.
//  4 Busy ignore: start pulses at cycles 5, 300, 528 -> exactly one transaction; no second cs fall
//    until a start after busy falls.
//  5 Back-to-back: start held high continuously -> transactions separated by exactly 2 cs-high cycles;
//    each done one cycle wide.
//  6 Subnode integration: connect to subnode (nk=8,nb=4) with AES core -> result equals reference
//    ciphertext for FIPS-197 AES-256 vector.

Source files
------------

// File: rtl/subnode_link_ctrl.sv
// Master-side sequencer for the serial subnode link: frames message + key under cs,
// waits out the subnode's processing gap, then shifts the processed block back in.
module subnode_link_ctrl #(
  parameter int nk       = 8,
  parameter int nb       = 4,
  parameter int nr       = 14,
  parameter int WAIT_CYC = nr + 2
) (
  input  logic              in_clk,
  input  logic              rst,
  input  logic              start,
  input  logic [32*nb-1:0]  msg_in,
  input  logic [32*nk-1:0]  key_in,
  input  logic              sdo,
  output logic              cs,
  output logic              sdi,
  output logic              busy,
  output logic              done,
  output logic [32*nb-1:0]  result
);

  localparam int W    = 32 * nb;
  localparam int KW   = 32 * nk;
  localparam int TW   = W + KW;
  localparam int M1   = (W > KW) ? W : KW;
  localparam int CMAX = (M1 > WAIT_CYC) ? M1 : WAIT_CYC;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    SEND_MSG,
    SEND_KEY,
    GAP,
    RECV,
    FIN
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   bit_cnt;
  logic [TW-1:0]   tx;
  logic [W-1:0]    rx;
  logic            state_chg;

  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start)                       state_d = SEND_MSG;
      SEND_MSG: if (bit_cnt == CW'(W - 1))        state_d = SEND_KEY;
      SEND_KEY: if (bit_cnt == CW'(KW - 1))       state_d = GAP;
      GAP:      if (bit_cnt == CW'(WAIT_CYC - 1)) state_d = RECV;
      RECV:     if (bit_cnt == CW'(W - 1))        state_d = FIN;
      FIN:                                       state_d = IDLE;
      default:                                   state_d = IDLE;
    endcase
  end

  assign state_chg = (state_d != state_q);

  // The counter restarts on every state change and is parked in IDLE/FIN, so it never wraps.
  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      bit_cnt <= '0;
      tx      <= '0;
      rx      <= '0;
      cs      <= 1'b1;
      sdi     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      if (state_chg || state_q == IDLE || state_q == FIN) bit_cnt <= '0;
      else                                                bit_cnt <= bit_cnt + 1'b1;

      case (state_q)
        IDLE: begin
          if (start) begin
            tx   <= {msg_in, key_in};
            cs   <= 1'b0;
            sdi  <= msg_in[W-1];
            busy <= 1'b1;
          end
        end
        SEND_MSG, SEND_KEY: begin
          tx  <= {tx[TW-2:0], 1'b0};
          sdi <= (state_d == GAP) ? 1'b0 : tx[TW-2];
        end
        GAP: begin
          sdi <= 1'b0;
        end
        RECV: begin
          rx <= {rx[W-2:0], sdo};
          // Last sample goes straight into result so done lines up with the first cs-high cycle.
          if (state_d == FIN) begin
            result <= {rx[W-2:0], sdo};
            done   <= 1'b1;
            cs     <= 1'b1;
          end
        end
        FIN: begin
          done <= 1'b0;
          busy <= 1'b0;
        end
        default: begin
          cs   <= 1'b1;
          busy <= 1'b0;
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_subnode_link_ctrl.sv
// Scoreboard bench for subnode_link_ctrl: stimulus queues expected frames/results, and a
// negedge monitor (which also plays the subnode's sdo side) pops and compares them.
module tb_subnode_link_ctrl;

  localparam int W     = 128;
  localparam int KW    = 256;
  localparam int WAITC = 16;
  localparam int TW    = W + KW;
  localparam int RX0   = TW + WAITC + 1;
  localparam int CSLOW = TW + WAITC + W;

  typedef struct {
    logic [W-1:0]  msg;
    logic [KW-1:0] key;
    logic [W-1:0]  ret;
  } txn_t;

  logic           in_clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   msg_in = '0;
  logic [KW-1:0]  key_in = '0;
  logic           sdo = 1'b0;
  logic           cs, sdi, busy, done;
  logic [W-1:0]   result;

  int   tests_run = 0;
  int   tests_failed = 0;
  int   done_cnt = 0;
  bit   b2b = 1'b0;
  txn_t exp_q[$];

  subnode_link_ctrl #(.nk(8), .nb(4), .nr(14)) dut (
    .in_clk (in_clk),
    .rst    (rst),
    .start  (start),
    .msg_in (msg_in),
    .key_in (key_in),
    .sdo    (sdo),
    .cs     (cs),
    .sdi    (sdi),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 in_clk = ~in_clk;

  task automatic checkOutput(input string name, input logic [TW-1:0] actual,
                             input logic [TW-1:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] msg, input logic [KW-1:0] key,
                               input logic [W-1:0] ret);
    txn_t t;
    t.msg = msg;
    t.key = key;
    t.ret = ret;
    @(negedge in_clk);
    exp_q.push_back(t);
    msg_in = msg;
    key_in = key;
    start  = 1'b1;
    @(negedge in_clk);
    start  = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge in_clk);
    start = 1'b1;
    @(negedge in_clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 3000) begin
      @(negedge in_clk);
      n++;
    end
    checkOutput("wait_done", done_cnt, target);
  endtask

  // Monitor plus subnode model: counts cs-low cycles, captures sdi, and drives sdo on the
  // falling edge so each result bit is stable at the controller's sampling edge.
  txn_t           cur;
  bit             in_txn = 1'b0;
  bit             have_prev = 1'b0;
  bit             done_prev = 1'b0;
  bit             tail_bad = 1'b0;
  int             low_cnt = 0;
  int             hi_cnt = 0;
  logic [TW-1:0]  stream = '0;

  always @(negedge in_clk) begin
    if (!rst) begin
      in_txn    = 1'b0;
      have_prev = 1'b0;
      done_prev = 1'b0;
      low_cnt   = 0;
      hi_cnt    = 0;
      sdo       = 1'b0;
    end else begin
      if (done_prev) checkOutput("done_width", done, 0);
      done_prev = done;
      if (cs == 1'b0) begin
        if (!in_txn) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_txn", 1, 0);
            cur.msg = '0;
            cur.key = '0;
            cur.ret = '0;
          end else begin
            cur = exp_q.pop_front();
          end
          if (b2b && have_prev) checkOutput("cs_high_gap", hi_cnt, 2);
          in_txn   = 1'b1;
          low_cnt  = 0;
          stream   = '0;
          tail_bad = 1'b0;
        end
        low_cnt++;
        if (low_cnt <= TW) stream[TW-low_cnt] = sdi;
        else if (sdi !== 1'b0) tail_bad = 1'b1;
        if (low_cnt >= RX0 && low_cnt < RX0 + W) sdo = cur.ret[W-1-(low_cnt-RX0)];
        else sdo = 1'b0;
      end else begin
        if (in_txn) begin
          checkOutput("cs_low_len", low_cnt, CSLOW);
          checkOutput("sdi_frame", stream, {cur.msg, cur.key});
          checkOutput("sdi_tail_zero", tail_bad, 0);
          in_txn    = 1'b0;
          hi_cnt    = 0;
          have_prev = 1'b1;
        end
        hi_cnt++;
        sdo = 1'b0;
      end
      if (done) begin
        checkOutput("done_latency", hi_cnt, 1);
        checkOutput("result", result, cur.ret);
        checkOutput("busy_at_done", busy, 1);
        done_cnt++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  localparam logic [W-1:0]  FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [KW-1:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [W-1:0]  FIPS_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [W-1:0]  RET_B    = 128'hdeadbeef_0badf00d_cafebabe_12345678;
  localparam logic [W-1:0]  EDGE_V   = 128'h80000000_00000000_00000000_00000001;
  localparam logic [KW-1:0] EDGE_K   = {1'b1, 254'd0, 1'b1};

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge in_clk);
    checkOutput("reset_cs", cs, 1);
    checkOutput("reset_sdi", sdi, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_result", result, 0);
    rst = 1'b1;
    repeat (3) @(negedge in_clk);

    // Frame and loopback: subnode answers with the FIPS-197 AES-256 ciphertext.
    applyStimulus(FIPS_PT, FIPS_KEY, FIPS_CT);
    wait_done(1);
    repeat (10) begin
      @(negedge in_clk);
      checkOutput("result_hold", result, FIPS_CT);
    end
    applyStimulus(EDGE_V, EDGE_K, RET_B);
    wait_done(2);
    repeat (10) begin
      @(negedge in_clk);
      checkOutput("result_hold", result, RET_B);
    end

    // Starts while busy (including the FIN->IDLE edge) must be dropped.
    applyStimulus(~FIPS_PT, ~FIPS_KEY, EDGE_V);
    repeat (297) @(negedge in_clk);
    pulse_start();
    repeat (227) @(negedge in_clk);
    @(negedge in_clk);
    start = 1'b1;
    @(negedge in_clk);
    @(negedge in_clk);
    start = 1'b0;
    wait_done(3);
    repeat (50) @(negedge in_clk);
    checkOutput("no_extra_txn", done_cnt, 3);
    checkOutput("idle_busy", busy, 0);
    applyStimulus(FIPS_PT, EDGE_K, ~RET_B);
    wait_done(4);

    // Asynchronous reset in the middle of the key phase.
    applyStimulus(FIPS_PT, FIPS_KEY, FIPS_CT);
    repeat (199) @(negedge in_clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_rst_cs", cs, 1);
    checkOutput("async_rst_busy", busy, 0);
    checkOutput("async_rst_done", done, 0);
    checkOutput("async_rst_result", result, 0);
    exp_q.delete();
    repeat (3) @(negedge in_clk);
    #2;
    rst = 1'b1;
    repeat (20) @(negedge in_clk);
    checkOutput("post_rst_idle_cs", cs, 1);
    checkOutput("post_rst_no_done", done_cnt, 4);

    // Start held high: three transactions back to back, two cs-high cycles apart.
    begin
      txn_t t;
      t.msg = EDGE_V;
      t.key = FIPS_KEY;
      for (int i = 0; i < 3; i++) begin
        t.ret = RET_B ^ {96'd0, 32'(i + 1)};
        exp_q.push_back(t);
      end
    end
    b2b = 1'b1;
    @(negedge in_clk);
    msg_in = EDGE_V;
    key_in = FIPS_KEY;
    start  = 1'b1;
    begin
      int n = 0;
      while (done_cnt < 7 && n < 3000) begin
        @(negedge in_clk);
        n++;
      end
    end
    start = 1'b0;
    checkOutput("b2b_done_count", done_cnt, 7);
    repeat (20) @(negedge in_clk);
    checkOutput("b2b_no_extra", done_cnt, 7);
    checkOutput("b2b_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
